// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//
// MEM stage of the 5-stage pipeline. Takes the EX/MEM register outputs,
// performs the data-memory access against a word-addressed RAM with a fixed
// multi-cycle latency, and registers the results into MEM/WB.
//
// Legal loads and stores hold the upstream pipeline (stall_o) for LATENCY
// cycles. The access itself happens on the edge that ends the last BUSY
// cycle, so EX/MEM advances on that same edge. Non-memory instructions pass
// through in one cycle. Misaligned accesses and read+write requests are
// rejected without touching the RAM and raise a one-cycle mem_err_o pulse.
//
// Parameters
//   DEPTH    data RAM depth in 32-bit words (power of two)
//   LATENCY  stall cycles per memory access (>= 1)
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous reset, active-high
//   reg_write_i    EX/MEM: instruction writes the register file
//   mem_to_reg_i   EX/MEM: WB selects memory data
//   mem_read_i     EX/MEM: load
//   mem_write_i    EX/MEM: store
//   alu_result_i   EX/MEM: ALU result, also the byte address
//   write_data_i   EX/MEM: store data
//   rd_i           EX/MEM: destination register
//   stall_o        combinational; hold all upstream pipeline registers
//   mem_err_o      registered one-cycle pulse on a rejected access
//   reg_write_o    MEM/WB: register-file write enable
//   mem_to_reg_o   MEM/WB: WB mux select
//   read_data_o    MEM/WB: loaded word
//   alu_result_o   MEM/WB: ALU result
//   rd_o           MEM/WB: destination register
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        reg_write_i,
  input  logic        mem_to_reg_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] write_data_i,
  input  logic [4:0]  rd_i,
  output logic        stall_o,
  output logic        mem_err_o,
  output logic        reg_write_o,
  output logic        mem_to_reg_o,
  output logic [31:0] read_data_o,
  output logic [31:0] alu_result_o,
  output logic [4:0]  rd_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CntInit = CW'(LATENCY - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;

  // Copy of the accepted request; EX/MEM inputs are ignored while BUSY.
  logic [AW-1:0] latAddr_q;
  logic [31:0]   latWData_q;
  logic [31:0]   latAlu_q;
  logic [4:0]    latRd_q;
  logic          latRead_q;
  logic          latWrite_q;
  logic          latRegWrite_q;
  logic          latMemToReg_q;

  // MEM/WB register.
  logic          wbRegWrite_q;
  logic          wbMemToReg_q;
  logic          wbErr_q;
  logic [31:0]   wbReadData_q;
  logic [31:0]   wbAlu_q;
  logic [4:0]    wbRd_q;

  logic [31:0]   ram [DEPTH];

  logic          req;
  logic          misaligned;
  logic          rwConflict;
  logic          legalReq;
  logic [AW-1:0] reqIdx;
  logic          busyWaiting;
  logic          accessDone;

  assign req        = mem_read_i | mem_write_i;
  assign misaligned = (alu_result_i[1:0] != 2'b00);
  assign rwConflict = mem_read_i & mem_write_i;
  assign legalReq   = req & ~misaligned & ~rwConflict;

  // Upper address bits are dropped, so addresses wrap around the RAM.
  assign reqIdx = alu_result_i[2 +: AW];

  assign busyWaiting = (state_q == BUSY) && (cnt_q != '0);
  assign accessDone  = (state_q == BUSY) && (cnt_q == '0);

  // Stall covers the accepting IDLE cycle plus every BUSY cycle but the last,
  // giving exactly LATENCY stall cycles. Reset overrides it so the pipeline
  // is never frozen while it is being cleared.
  assign stall_o = ~rst_i & (((state_q == IDLE) & legalReq) | busyWaiting);

  // Control FSM, request latch and MEM/WB register. Every stalled edge loads
  // a bubble (no write-back, no error) while data fields hold their value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      latAddr_q     <= '0;
      latWData_q    <= '0;
      latAlu_q      <= '0;
      latRd_q       <= '0;
      latRead_q     <= 1'b0;
      latWrite_q    <= 1'b0;
      latRegWrite_q <= 1'b0;
      latMemToReg_q <= 1'b0;
      wbRegWrite_q  <= 1'b0;
      wbMemToReg_q  <= 1'b0;
      wbErr_q       <= 1'b0;
      wbReadData_q  <= '0;
      wbAlu_q       <= '0;
      wbRd_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (legalReq) begin
            latAddr_q     <= reqIdx;
            latWData_q    <= write_data_i;
            latAlu_q      <= alu_result_i;
            latRd_q       <= rd_i;
            latRead_q     <= mem_read_i;
            latWrite_q    <= mem_write_i;
            latRegWrite_q <= reg_write_i;
            latMemToReg_q <= mem_to_reg_i;
            cnt_q         <= CntInit;
            state_q       <= BUSY;
            wbRegWrite_q  <= 1'b0;
            wbMemToReg_q  <= 1'b0;
            wbErr_q       <= 1'b0;
          end else if (req) begin
            // Rejected access: report it and suppress the write-back.
            wbErr_q       <= 1'b1;
            wbRegWrite_q  <= 1'b0;
            wbMemToReg_q  <= 1'b0;
            wbAlu_q       <= alu_result_i;
            wbRd_q        <= rd_i;
          end else begin
            wbErr_q       <= 1'b0;
            wbRegWrite_q  <= reg_write_i;
            wbMemToReg_q  <= mem_to_reg_i;
            wbAlu_q       <= alu_result_i;
            wbRd_q        <= rd_i;
          end
        end

        BUSY: begin
          if (cnt_q != '0) begin
            cnt_q        <= cnt_q - CW'(1);
            wbRegWrite_q <= 1'b0;
            wbMemToReg_q <= 1'b0;
            wbErr_q      <= 1'b0;
          end else begin
            if (latRead_q) begin
              wbReadData_q <= ram[latAddr_q];
            end
            wbErr_q       <= 1'b0;
            wbRegWrite_q  <= latRegWrite_q;
            wbMemToReg_q  <= latMemToReg_q;
            wbAlu_q       <= latAlu_q;
            wbRd_q        <= latRd_q;
            state_q       <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // RAM write port. Reset blocks the write so an aborted store leaves the
  // RAM untouched; the array itself is never cleared.
  always_ff @(posedge clk_i) begin
    if (!rst_i && accessDone && latWrite_q) begin
      ram[latAddr_q] <= latWData_q;
    end
  end

  assign mem_err_o    = wbErr_q;
  assign reg_write_o  = wbRegWrite_q;
  assign mem_to_reg_o = wbMemToReg_q;
  assign read_data_o  = wbReadData_q;
  assign alu_result_o = wbAlu_q;
  assign rd_o         = wbRd_q;

endmodule
